// File: rtl/apple_riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apple_riscv_pkg
// Description : Shared RV32I constants, ALU operation enum and ALU helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package apple_riscv_pkg;

    localparam int XLEN = 32;

    // Major opcodes of the supported RV32I subset
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // funct3 values
    localparam logic [2:0] F3_JALR = 3'd0;
    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;
    localparam logic [2:0] F3_LW   = 3'd2;
    localparam logic [2:0] F3_SW   = 3'd2;
    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

    // Map funct3 plus the instr[30] "alternate" bit onto an ALU operation.
    function automatic alu_op_t decode_alu(input logic [2:0] funct3, input logic alt);
        case (funct3)
            F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // 32-bit wrap-around ALU; shifts use only the low five bits of b.
    function automatic logic [XLEN-1:0] alu_exec(input alu_op_t op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << sh;
            ALU_SLT:  return {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: return {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> sh;
            ALU_SRA:  return $unsigned($signed(a) >>> sh);
            ALU_OR:   return a | b;
            default:  return a & b;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_ram.sv
`default_nettype none
// ============================================================================
// Module      : instr_ram
// Description : Instruction memory, combinational word read, no write port.
//               Contents are preloaded from outside; never cleared by reset.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic [AW-1:0] addr,
    output logic [31:0]   data
);

    logic [31:0] ram [0:DEPTH-1];

    assign data = ram[addr];

endmodule
`default_nettype wire

// File: rtl/apple_riscv_soc_top.sv
`default_nettype none
// ============================================================================
// Module      : apple_riscv_soc_top
// Description : Single-cycle RV32I SoC: core, register file, data RAM inline,
//               instruction RAM as a sub-module. Only clk and reset are pins.
// Revision    : 1.0 - initial release
// ============================================================================
module apple_riscv_soc_top
    import apple_riscv_pkg::*;
#(
    parameter int              IRAM_DEPTH = 1024,
    parameter int              DRAM_DEPTH = 1024,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0
) (
    input logic clk,
    input logic reset
);

    localparam int IRAM_AW = $clog2(IRAM_DEPTH);
    localparam int DRAM_AW = $clog2(DRAM_DEPTH);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] pc_plus4;
    logic [31:0]     instr;
    logic [XLEN-1:0] u_regs [0:31];

    instr_ram #(
        .DEPTH (IRAM_DEPTH),
        .AW    (IRAM_AW)
    ) instruction_ram (
        .addr (pc[IRAM_AW+1:2]),
        .data (instr)
    );

    // Instruction fields and immediates
    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] funct3;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // x0 is never written, so it always reads back as zero
    logic [XLEN-1:0] rs1_val, rs2_val;
    assign rs1_val  = u_regs[rs1];
    assign rs2_val  = u_regs[rs2];
    assign pc_plus4 = pc + 32'd4;

    // Data RAM: word addressed, low address bits ignored, wraps modulo depth
    logic [XLEN-1:0]    mem_addr;
    logic [DRAM_AW-1:0] dram_idx;
    logic [XLEN-1:0]    dram_rdata;
    logic               mem_we;

    assign mem_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
    assign dram_idx = mem_addr[DRAM_AW+1:2];

    if (1) begin : data_ram
        logic [XLEN-1:0] ram [0:DRAM_DEPTH-1];

        // Word store at the clock edge; a held reset never disturbs memory
        always_ff @(posedge clk) begin
            if (mem_we && !reset) begin
                ram[dram_idx] <= rs2_val;
            end
        end

        assign dram_rdata = ram[dram_idx];
    end

    // Branch condition evaluation; unsupported funct3 makes the branch a NOP
    logic br_valid, br_taken;
    always_comb begin
        br_valid = 1'b1;
        br_taken = 1'b0;
        case (funct3)
            F3_BEQ:  br_taken = (rs1_val == rs2_val);
            F3_BNE:  br_taken = (rs1_val != rs2_val);
            F3_BLT:  br_taken = ($signed(rs1_val) <  $signed(rs2_val));
            F3_BGE:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
            F3_BLTU: br_taken = (rs1_val <  rs2_val);
            F3_BGEU: br_taken = (rs1_val >= rs2_val);
            default: br_valid = 1'b0;
        endcase
    end

    // Decode and execute: next PC, register writeback and store enable
    logic            rd_we;
    logic [XLEN-1:0] rd_data;
    logic            imm_alt;
    assign imm_alt = (funct3 == F3_SR) ? instr[30] : 1'b0;

    always_comb begin
        next_pc = pc_plus4;
        rd_we   = 1'b0;
        rd_data = '0;
        mem_we  = 1'b0;
        case (opcode)
            OP_LUI: begin
                rd_we   = 1'b1;
                rd_data = imm_u;
            end
            OP_AUIPC: begin
                rd_we   = 1'b1;
                rd_data = pc + imm_u;
            end
            OP_JAL: begin
                rd_we   = 1'b1;
                rd_data = pc_plus4;
                next_pc = pc + imm_j;
            end
            OP_JALR: begin
                if (funct3 == F3_JALR) begin
                    rd_we   = 1'b1;
                    rd_data = pc_plus4;
                    next_pc = (rs1_val + imm_i) & ~32'd1;
                end
            end
            OP_BRANCH: begin
                if (br_valid && br_taken) begin
                    next_pc = pc + imm_b;
                end
            end
            OP_LOAD: begin
                if (funct3 == F3_LW) begin
                    rd_we   = 1'b1;
                    rd_data = dram_rdata;
                end
            end
            OP_STORE: begin
                mem_we = (funct3 == F3_SW);
            end
            OP_IMM: begin
                rd_we   = 1'b1;
                rd_data = alu_exec(decode_alu(funct3, imm_alt), rs1_val, imm_i);
            end
            OP_REG: begin
                rd_we   = 1'b1;
                rd_data = alu_exec(decode_alu(funct3, instr[30]), rs1_val, rs2_val);
            end
            default: ;
        endcase
    end

    // Program counter: async reset to RESET_PC, one instruction per edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc;
        end
    end

    // Register file: async clear, write at the edge, x0 writes dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                u_regs[i] <= '0;
            end
        end else if (rd_we && (rd != 5'd0)) begin
            u_regs[rd] <= rd_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apple_riscv_soc_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_apple_riscv_soc_top
// Description : Self-checking bench for apple_riscv_soc_top: directed
//               programs plus randomized ALU/branch programs against an
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apple_riscv_soc_top;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    logic [31:0] prog [$];

    apple_riscv_soc_top dut (
        .clk   (clk),
        .reset (reset)
    );

    always #5 clk = ~clk;

    // ---------------- instruction encoders ----------------
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [11:0] imm);
        return enc_i(imm, rs1, 3'd0, rd, 7'b0010011);
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_alu(input logic [2:0] f3, input bit alt,
                                            input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (f3)
            3'd0:    return alt ? a - b : a + b;
            3'd1:    return a << sh;
            3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return alt ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            default: return a >= b;
        endcase
    endfunction

    // ---------------- helpers ----------------
    task automatic load_and_reset(input int hold);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            dut.instruction_ram.ram[i] = (i < prog.size()) ? prog[i] : 32'h0;
        end
        repeat (hold) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        prog = '{addi(5'd1, 5'd0, 12'd5)};
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            dut.instruction_ram.ram[i] = (i < prog.size()) ? prog[i] : 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (dut.pc !== 32'h0) begin
            bad++;
            $display("FAIL reset_pc got=%h exp=%h", dut.pc, 32'h0);
        end
        for (int i = 0; i < 32; i++) begin
            total++;
            if (dut.u_regs[i] !== 32'h0) begin
                bad++;
                $display("FAIL reset_reg x%0d got=%h exp=%h", i, dut.u_regs[i], 32'h0);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        step(1);
        total++;
        if (dut.u_regs[1] !== 32'd5) begin
            bad++;
            $display("FAIL reset_release_x1 got=%h exp=%h", dut.u_regs[1], 32'd5);
        end
    endtask

    task automatic test_alu();
        prog = '{addi(5'd1, 5'd0, 12'hFFF),
                 enc_i(12'd28, 5'd1, 3'd5, 5'd2, 7'b0010011),
                 enc_i({7'h20, 5'd28}, 5'd1, 3'd5, 5'd3, 7'b0010011),
                 enc_r(7'h0, 5'd1, 5'd0, 3'd3, 5'd4)};
        load_and_reset(2);
        step(4);
        total++;
        if (dut.u_regs[2] !== 32'hF) begin
            bad++; $display("FAIL alu_srli got=%h exp=%h", dut.u_regs[2], 32'hF);
        end
        total++;
        if (dut.u_regs[3] !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL alu_srai got=%h exp=%h", dut.u_regs[3], 32'hFFFF_FFFF);
        end
        total++;
        if (dut.u_regs[4] !== 32'd1) begin
            bad++; $display("FAIL alu_sltu got=%h exp=%h", dut.u_regs[4], 32'd1);
        end
    endtask

    task automatic test_memory();
        prog = '{addi(5'd1, 5'd0, 12'h055),
                 enc_s(12'd8, 5'd1, 5'd0),
                 enc_i(12'd8, 5'd0, 3'd2, 5'd2, 7'b0000011)};
        load_and_reset(2);
        step(3);
        total++;
        if (dut.data_ram.ram[2] !== 32'h55) begin
            bad++; $display("FAIL mem_store got=%h exp=%h", dut.data_ram.ram[2], 32'h55);
        end
        total++;
        if (dut.u_regs[2] !== 32'h55) begin
            bad++; $display("FAIL mem_load got=%h exp=%h", dut.u_regs[2], 32'h55);
        end
    endtask

    task automatic test_branch_jump();
        prog = '{addi(5'd1, 5'd0, 12'd1),
                 enc_b(13'd8, 5'd0, 5'd1, 3'd0),
                 enc_j(21'd8, 5'd5)};
        load_and_reset(2);
        step(3);
        total++;
        if (dut.u_regs[5] !== 32'd12) begin
            bad++; $display("FAIL jal_link got=%h exp=%h", dut.u_regs[5], 32'd12);
        end
        total++;
        if (dut.pc !== 32'd16) begin
            bad++; $display("FAIL jal_pc got=%h exp=%h", dut.pc, 32'd16);
        end
        // jalr with rd == rs1: target uses the old rs1, link overwrites it
        prog = '{addi(5'd1, 5'd0, 12'd16),
                 enc_i(12'd1, 5'd1, 3'd0, 5'd1, 7'b1100111)};
        load_and_reset(2);
        step(2);
        total++;
        if (dut.pc !== 32'd16) begin
            bad++; $display("FAIL jalr_pc got=%h exp=%h", dut.pc, 32'd16);
        end
        total++;
        if (dut.u_regs[1] !== 32'd8) begin
            bad++; $display("FAIL jalr_link got=%h exp=%h", dut.u_regs[1], 32'd8);
        end
    endtask

    task automatic test_x0_illegal();
        prog = '{addi(5'd0, 5'd0, 12'd7), 32'h0000_0000};
        load_and_reset(2);
        step(1);
        total++;
        if (dut.u_regs[0] !== 32'h0) begin
            bad++; $display("FAIL x0_write got=%h exp=%h", dut.u_regs[0], 32'h0);
        end
        total++;
        if (dut.pc !== 32'd4) begin
            bad++; $display("FAIL x0_pc got=%h exp=%h", dut.pc, 32'd4);
        end
        step(1);
        total++;
        if (dut.pc !== 32'd8) begin
            bad++; $display("FAIL illegal_pc got=%h exp=%h", dut.pc, 32'd8);
        end
    endtask

    task automatic test_async_reset();
        prog = '{addi(5'd1, 5'd0, 12'h077), enc_s(12'd12, 5'd1, 5'd0)};
        load_and_reset(2);
        step(8);
        total++;
        if (dut.pc !== 32'h20) begin
            bad++; $display("FAIL arst_prerun_pc got=%h exp=%h", dut.pc, 32'h20);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (dut.pc !== 32'h0) begin
            bad++; $display("FAIL arst_pc got=%h exp=%h", dut.pc, 32'h0);
        end
        total++;
        if (dut.u_regs[1] !== 32'h0) begin
            bad++; $display("FAIL arst_reg got=%h exp=%h", dut.u_regs[1], 32'h0);
        end
        total++;
        if (dut.data_ram.ram[3] !== 32'h77) begin
            bad++; $display("FAIL arst_dram got=%h exp=%h", dut.data_ram.ram[3], 32'h77);
        end
        @(negedge clk);
        reset = 1'b0;
        step(1);
        total++;
        if (dut.pc !== 32'd4) begin
            bad++; $display("FAIL arst_restart_pc got=%h exp=%h", dut.pc, 32'd4);
        end
    endtask

    task automatic test_random_alu_branch();
        logic [2:0] br_f3s [6];
        logic [31:0] a, b, hi, exp_r, exp_i, imm_ext, exp_pc;
        logic [11:0] imm;
        logic [2:0]  rf3, if3, bf3;
        bit          ralt, ialt, taken;
        br_f3s = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        for (int it = 0; it < 24; it++) begin
            a = $urandom();
            b = ($urandom_range(0, 3) == 0) ? a : $urandom();
            rf3  = 3'($urandom_range(0, 7));
            ralt = (rf3 == 3'd0 || rf3 == 3'd5) ? bit'($urandom_range(0, 1)) : 1'b0;
            if3  = 3'($urandom_range(0, 7));
            ialt = (if3 == 3'd5) ? bit'($urandom_range(0, 1)) : 1'b0;
            if (if3 == 3'd1 || if3 == 3'd5) begin
                imm = {ialt ? 7'h20 : 7'h00, 5'($urandom_range(0, 31))};
            end else begin
                imm = 12'($urandom());
            end
            imm_ext = {{20{imm[11]}}, imm};
            bf3   = br_f3s[$urandom_range(0, 5)];
            exp_r = ref_alu(rf3, ralt, a, b);
            exp_i = ref_alu(if3, ialt, a, imm_ext);
            taken = ref_taken(bf3, a, b);
            exp_pc = taken ? 32'd40 : 32'd36;
            prog.delete();
            hi = (a + 32'h800) >> 12;
            prog.push_back(enc_u(hi[19:0], 5'd1, 7'b0110111));
            prog.push_back(addi(5'd1, 5'd1, a[11:0]));
            hi = (b + 32'h800) >> 12;
            prog.push_back(enc_u(hi[19:0], 5'd2, 7'b0110111));
            prog.push_back(addi(5'd2, 5'd2, b[11:0]));
            prog.push_back(enc_r(ralt ? 7'h20 : 7'h00, 5'd2, 5'd1, rf3, 5'd3));
            prog.push_back(enc_i(imm, 5'd1, if3, 5'd4, 7'b0010011));
            prog.push_back(enc_b(13'd8, 5'd2, 5'd1, bf3));
            prog.push_back(addi(5'd6, 5'd0, 12'd1));
            prog.push_back(addi(5'd7, 5'd0, 12'd1));
            load_and_reset(1);
            step(9);
            total++;
            if (dut.u_regs[3] !== exp_r) begin
                bad++;
                $display("FAIL rand_reg_op it=%0d f3=%0d alt=%0d a=%h b=%h got=%h exp=%h",
                         it, rf3, ralt, a, b, dut.u_regs[3], exp_r);
            end
            total++;
            if (dut.u_regs[4] !== exp_i) begin
                bad++;
                $display("FAIL rand_imm_op it=%0d f3=%0d imm=%h a=%h got=%h exp=%h",
                         it, if3, imm, a, dut.u_regs[4], exp_i);
            end
            total++;
            if (dut.u_regs[6] !== (taken ? 32'd0 : 32'd1) || dut.u_regs[7] !== 32'd1) begin
                bad++;
                $display("FAIL rand_branch it=%0d f3=%0d a=%h b=%h x6=%h x7=%h taken_exp=%0d",
                         it, bf3, a, b, dut.u_regs[6], dut.u_regs[7], taken);
            end
            total++;
            if (dut.pc !== exp_pc) begin
                bad++;
                $display("FAIL rand_pc it=%0d got=%h exp=%h", it, dut.pc, exp_pc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_memory();
        test_branch_jump();
        test_x0_illegal();
        test_async_reset();
        test_random_alu_branch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
